// File: rtl/div_iter_if.sv
// EX1 / EX2 side bundle for the iterative divider.
// master = pipeline stages, slave = divider.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [4:0]       rd_in;
  logic             out_allowin;
  logic             stall_divider;
  logic             div_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [4:0]       rd_out;

  modport master (
    output flush,
    output start,
    output signed_op,
    output dividend,
    output divisor,
    output rd_in,
    output out_allowin,
    input  stall_divider,
    input  div_ready,
    input  quotient,
    input  remainder,
    input  rd_out
  );

  modport slave (
    input  flush,
    input  start,
    input  signed_op,
    input  dividend,
    input  divisor,
    input  rd_in,
    input  out_allowin,
    output stall_divider,
    output div_ready,
    output quotient,
    output remainder,
    output rd_out
  );
endinterface

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU.
// One quotient bit per cycle; result held in DONE until accepted.
module div_iter_unit #(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] DIV0_QUOTIENT = {WIDTH{1'b1}}
) (
  input logic     clk,
  input logic     aresetn,
  div_iter_if.slave io
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             q_neg;
  logic             r_neg;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [4:0]       rd_r;

  logic             accept;
  logic             div_zero;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign accept   = (state == S_IDLE) & io.start & ~io.flush;
  assign div_zero = (io.divisor == '0);

  assign abs_a = (io.signed_op & io.dividend[WIDTH-1])
               ? -io.dividend : io.dividend;
  assign abs_b = (io.signed_op & io.divisor[WIDTH-1])
               ? -io.divisor : io.divisor;

  // Partial remainder stays below the divisor, so WIDTH bits hold it;
  // the extra top bit only appears transiently after the shift.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign take    = ~diff[WIDTH];
  assign rem_nx  = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nx  = {dvd_q[WIDTH-2:0], take};

  assign q_fin = q_neg ? -quo_nx : quo_nx;
  assign r_fin = r_neg ? -rem_nx : rem_nx;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rd_q  <= '0;
      quo_r <= '0;
      rem_r <= '0;
      rd_r  <= '0;
    end else if (io.flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (io.start) begin
            if (div_zero) begin
              state <= S_DONE;
              quo_r <= DIV0_QUOTIENT;
              rem_r <= io.dividend;
              rd_r  <= io.rd_in;
            end else begin
              state <= S_CALC;
              cnt   <= CW'(WIDTH - 1);
              dvd_q <= abs_a;
              dvs_q <= abs_b;
              rem_q <= '0;
              q_neg <= io.signed_op &
                       (io.dividend[WIDTH-1] ^ io.divisor[WIDTH-1]);
              r_neg <= io.signed_op & io.dividend[WIDTH-1];
              rd_q  <= io.rd_in;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_nx;
          dvd_q <= quo_nx;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= S_DONE;
            quo_r <= q_fin;
            rem_r <= r_fin;
            rd_r  <= rd_q;
          end
        end
        S_DONE: begin
          if (io.out_allowin) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.stall_divider = (state == S_CALC) | accept |
                            ((state == S_DONE) & ~io.out_allowin);
  assign io.div_ready     = (state == S_DONE);
  assign io.quotient      = quo_r;
  assign io.remainder     = rem_r;
  assign io.rd_out        = rd_r;

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed cases, flush,
// backpressure, mid-op reset and a few random operands.
module tb_div_iter_unit;

  logic clk = 1'b0;
  logic aresetn;
  int   n_vec = 0;
  int   n_err = 0;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter_unit #(
    .WIDTH        (32),
    .DIV0_QUOTIENT(32'hFFFF_FFFF)
  ) dut (
    .clk    (clk),
    .aresetn(aresetn),
    .io     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic sg, input logic [4:0] rd);
    exp_t e;
    logic [31:0] ma, mb, uq, ur;
    e.rd = rd;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else begin
      ma = (sg && a[31]) ? (32'd0 - a) : a;
      mb = (sg && b[31]) ? (32'd0 - b) : b;
      uq = ma / mb;
      ur = ma % mb;
      e.q = (sg && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
      e.r = (sg && a[31]) ? (32'd0 - ur) : ur;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (aresetn && bus.div_ready && bus.out_allowin) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_q", bus.quotient, e.q);
        check("sb_r", bus.remainder, e.r);
        check("sb_rd", {27'd0, bus.rd_out}, {27'd0, e.rd});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [4:0] rd,
                        input bit push);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.signed_op = sg;
    bus.rd_in     = rd;
    if (push) sb.push_back(model(a, b, sg, rd));
    #1;
    check("stall_req", 32'(bus.stall_divider), 32'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input int max, input int poke,
                            output int cyc, output bit stall_ok);
    cyc      = 1;
    stall_ok = 1'b1;
    while (!bus.div_ready && cyc < max) begin
      if (!bus.stall_divider) stall_ok = 1'b0;
      if (cyc == poke) begin
        bus.start    = 1'b1;
        bus.dividend = 32'h1234_5678;
        bus.divisor  = 32'd3;
        bus.rd_in    = 5'd31;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    int          cyc;
    bit          ok;
    bit          saw;
    logic [31:0] q0, r0, a, b;
    logic [4:0]  rd0;

    bus.flush       = 1'b0;
    bus.start       = 1'b0;
    bus.signed_op   = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;
    bus.rd_in       = '0;
    bus.out_allowin = 1'b1;
    aresetn         = 1'b0;
    repeat (3) step();
    check("rst_q", bus.quotient, 32'd0);
    check("rst_r", bus.remainder, 32'd0);
    check("rst_rd", {27'd0, bus.rd_out}, 32'd0);
    check("rst_ready", 32'(bus.div_ready), 32'd0);
    check("rst_stall", 32'(bus.stall_divider), 32'd0);
    aresetn = 1'b1;
    step();

    // unsigned 100/7
    launch(32'd100, 32'd7, 1'b0, 5'd5, 1'b1);
    wait_ready(60, 0, cyc, ok);
    check("lat_u", 32'(cyc), 32'd33);
    check("stall_calc_u", 32'(ok), 32'd1);
    check("stall_done_u", 32'(bus.stall_divider), 32'd0);
    check("q_u", bus.quotient, 32'd14);
    check("r_u", bus.remainder, 32'd2);
    check("rd_u", {27'd0, bus.rd_out}, 32'd5);
    step();
    check("idle_u", 32'(bus.div_ready), 32'd0);

    // signed -7/2 and 7/-2
    launch(32'hFFFF_FFF9, 32'd2, 1'b1, 5'd6, 1'b1);
    wait_ready(60, 0, cyc, ok);
    check("q_s1", bus.quotient, 32'hFFFF_FFFD);
    check("r_s1", bus.remainder, 32'hFFFF_FFFF);
    step();
    launch(32'd7, 32'hFFFF_FFFE, 1'b1, 5'd7, 1'b1);
    wait_ready(60, 0, cyc, ok);
    check("q_s2", bus.quotient, 32'hFFFF_FFFD);
    check("r_s2", bus.remainder, 32'd1);
    step();

    // signed overflow
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd8, 1'b1);
    wait_ready(60, 0, cyc, ok);
    check("lat_ovf", 32'(cyc), 32'd33);
    check("q_ovf", bus.quotient, 32'h8000_0000);
    check("r_ovf", bus.remainder, 32'd0);
    step();

    // zero divisor
    launch(32'd5, 32'd0, 1'b0, 5'd9, 1'b1);
    wait_ready(60, 0, cyc, ok);
    check("lat_div0", 32'(cyc), 32'd1);
    check("q_div0", bus.quotient, 32'hFFFF_FFFF);
    check("r_div0", bus.remainder, 32'd5);
    step();

    // start poked during CALC must not disturb the operation
    launch(32'd1000, 32'd9, 1'b0, 5'd10, 1'b1);
    wait_ready(60, 5, cyc, ok);
    check("lat_poke", 32'(cyc), 32'd33);
    check("q_poke", bus.quotient, 32'd111);
    step();
    check("idle_poke", 32'(bus.div_ready), 32'd0);

    // flush at N+10, restart at N+11
    launch(32'd50, 32'd5, 1'b0, 5'd3, 1'b0);
    saw = 1'b0;
    repeat (9) begin
      if (bus.div_ready) saw = 1'b1;
      step();
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    if (bus.div_ready) saw = 1'b1;
    check("flush_ready", 32'(saw), 32'd0);
    check("flush_stall", 32'(bus.stall_divider), 32'd0);
    launch(32'd9, 32'd3, 1'b0, 5'd4, 1'b1);
    wait_ready(60, 0, cyc, ok);
    check("lat_flush", 32'(cyc), 32'd33);
    check("q_flush", bus.quotient, 32'd3);
    check("r_flush", bus.remainder, 32'd0);
    step();

    // backpressure for three cycles
    bus.out_allowin = 1'b0;
    launch(32'd200, 32'd9, 1'b0, 5'd12, 1'b1);
    wait_ready(60, 0, cyc, ok);
    check("lat_bp", 32'(cyc), 32'd33);
    q0  = bus.quotient;
    r0  = bus.remainder;
    rd0 = bus.rd_out;
    check("q_bp", q0, 32'd22);
    check("r_bp", r0, 32'd2);
    repeat (3) begin
      check("bp_ready", 32'(bus.div_ready), 32'd1);
      check("bp_stall", 32'(bus.stall_divider), 32'd1);
      check("bp_q", bus.quotient, q0);
      check("bp_r", bus.remainder, r0);
      check("bp_rd", {27'd0, bus.rd_out}, {27'd0, rd0});
      step();
    end
    bus.out_allowin = 1'b1;
    #1;
    check("bp_release", 32'(bus.stall_divider), 32'd0);
    step();
    check("bp_idle", 32'(bus.div_ready), 32'd0);
    check("bp_hold_q", bus.quotient, 32'd22);

    // reset in the middle of CALC
    launch(32'd77, 32'd4, 1'b0, 5'd2, 1'b0);
    repeat (14) step();
    aresetn = 1'b0;
    step();
    check("mrst_q", bus.quotient, 32'd0);
    check("mrst_r", bus.remainder, 32'd0);
    check("mrst_rd", {27'd0, bus.rd_out}, 32'd0);
    check("mrst_ready", 32'(bus.div_ready), 32'd0);
    aresetn = 1'b1;
    step();

    // random operands, both signednesses, some zero divisors
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i == 3) b = 32'h0000_0013;
      launch(a, b, 1'(i % 2), 5'(i + 13), 1'b1);
      wait_ready(60, 0, cyc, ok);
      check("lat_rand", 32'(cyc), (b == 32'd0) ? 32'd1 : 32'd33);
      step();
    end

    repeat (2) step();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
